debounce_bank: RTL and testbench

//  N-channel debouncer for pushbuttons and switches. Each channel has its own synchroniser,
//  a glitch-restarting filter counter and one-cycle rise/fall pulses.
//  A shared prescaler sets the filter time, so long debounce times do not need wide counters.

---
 rtl/debounce_bank_pkg.sv | 17 +
 rtl/debounce_chan.sv | 88 ++++++++
 rtl/debounce_bank.sv | 61 ++++++
 tb/tb_debounce_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared types and defaults for the debounce bank and other pin-facing blocks.
// A channel's phase is decoded from its filter counter: zero is idle, non-zero is counting.
package debounce_bank_pkg;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_COUNT = 1'b1
  } chan_phase_e;

  localparam int DEF_CNT_W       = 12;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int presc_w(input int prescale);
    return $clog2(prescale) + 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, glitch-restarting filter counter, edge pulses.
// evt_o is the next-cycle pulse so the top can register any_change alongside rise/fall.
module debounce_chan
  import debounce_bank_pkg::*;
#(
  parameter int   CNT_W       = DEF_CNT_W,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INIT        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic pb_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cand_q, cand_d;
  logic                   state_q, state_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  chan_phase_e            phase;

  assign s     = sync_q[SYNC_STAGES-1];
  assign phase = (cnt_q == '0) ? CH_IDLE : CH_COUNT;

  always_comb begin
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (phase)
      CH_IDLE: begin
        if (s != state_q) begin
          cand_d = s;
          cnt_d  = CNT_W'(1);
        end
      end
      CH_COUNT: begin
        // A mismatch beats a pending commit, so max never wraps or commits a glitch.
        if (s != cand_q) begin
          cnt_d  = '0;
          cand_d = state_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d = cand_q;
          cnt_d   = '0;
          rise_d  = cand_q;
          fall_d  = ~cand_q;
        end else if (tick_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{INIT}};
      cnt_q   <= '0;
      cand_q  <= INIT;
      state_q <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pb_i};
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_o   = rise_d | fall_d;

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer: shared prescaler sets the filter tick rate, one debounce_chan per pin,
// and a registered any_change that lines up with the rise/fall pulses.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int                  CHANNELS    = 4,
  parameter int                  CNT_W       = DEF_CNT_W,
  parameter int                  PRESCALE    = 1,
  parameter int                  SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [CHANNELS-1:0] INIT_STATE  = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] pb_i,
  output logic [CHANNELS-1:0] state_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                any_change_o
);

  localparam int PW = presc_w(PRESCALE);

  logic [PW-1:0]       pre_q, pre_d;
  logic                tick;
  logic [CHANNELS-1:0] evt;
  logic                any_q;

  // With PRESCALE=1 the counter sits at 0 and tick is permanently high.
  assign tick  = (pre_q == PW'(PRESCALE - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
      any_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      any_q <= |evt;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .INIT       (INIT_STATE[i])
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_i (tick),
      .pb_i   (pb_i[i]),
      .state_o(state_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .evt_o  (evt[i])
    );
  end

  assign any_change_o = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: three instances (prescale 1, prescale 4, all-ones reset value)
// checked every cycle against a rule-level model, plus directed latency/glitch/reset scenarios.
module tb_debounce_bank;

  localparam int MAXN = 14;  // agreeing ticks needed before a commit with CNT_W=4

  logic       clk;
  logic       rst [3];
  logic [3:0] pb  [3];
  logic [3:0] st  [3];
  logic [3:0] ri  [3];
  logic [3:0] fa  [3];
  logic       an  [3];

  int checks   = 0;
  int failures = 0;

  debounce_bank #(.CHANNELS(4), .CNT_W(4), .PRESCALE(1), .SYNC_STAGES(2), .INIT_STATE(4'h0)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .pb_i(pb[0]), .state_o(st[0]), .rise_o(ri[0]), .fall_o(fa[0]),
    .any_change_o(an[0]));
  debounce_bank #(.CHANNELS(4), .CNT_W(4), .PRESCALE(4), .SYNC_STAGES(2), .INIT_STATE(4'h0)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .pb_i(pb[1]), .state_o(st[1]), .rise_o(ri[1]), .fall_o(fa[1]),
    .any_change_o(an[1]));
  debounce_bank #(.CHANNELS(4), .CNT_W(4), .PRESCALE(1), .SYNC_STAGES(2), .INIT_STATE(4'hF)) dut_c (
    .clk_i(clk), .rst_i(rst[2]), .pb_i(pb[2]), .state_o(st[2]), .rise_o(ri[2]), .fall_o(fa[2]),
    .any_change_o(an[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ps(input int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic logic [3:0] init_of(input int k);
    return (k == 2) ? 4'hF : 4'h0;
  endfunction

  // Reference model: pin delayed two clocks, then a pending candidate that needs MAXN
  // agreeing ticks before it is accepted; any disagreement drops the candidate.
  logic [3:0] m_s1 [3], m_s2 [3], m_st [3], m_cand [3], m_ri [3], m_fa [3];
  logic       m_an [3];
  int         m_pre [3];
  bit         m_pend [3][4];
  int         m_n [3][4];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic       tk;
      logic [3:0] nst, nr, nf;
      if (rst[k]) begin
        m_s1[k] <= init_of(k); m_s2[k] <= init_of(k);
        m_st[k] <= init_of(k); m_cand[k] <= init_of(k);
        m_ri[k] <= '0; m_fa[k] <= '0; m_an[k] <= 1'b0; m_pre[k] <= 0;
        for (int c = 0; c < 4; c++) begin
          m_pend[k][c] <= 1'b0;
          m_n[k][c]    <= 0;
        end
      end else begin
        tk  = (m_pre[k] == ps(k) - 1);
        nst = m_st[k];
        nr  = '0;
        nf  = '0;
        m_pre[k] <= tk ? 0 : m_pre[k] + 1;
        m_s1[k]  <= pb[k];
        m_s2[k]  <= m_s1[k];
        for (int c = 0; c < 4; c++) begin
          if (!m_pend[k][c]) begin
            if (m_s2[k][c] != m_st[k][c]) begin
              m_pend[k][c] <= 1'b1;
              m_cand[k][c] <= m_s2[k][c];
              m_n[k][c]    <= 0;
            end
          end else if (m_s2[k][c] != m_cand[k][c]) begin
            m_pend[k][c] <= 1'b0;
          end else if (m_n[k][c] == MAXN) begin
            m_pend[k][c] <= 1'b0;
            nst[c] = m_cand[k][c];
            nr[c]  = m_cand[k][c];
            nf[c]  = ~m_cand[k][c];
          end else if (tk) begin
            m_n[k][c] <= m_n[k][c] + 1;
          end
        end
        m_st[k] <= nst;
        m_ri[k] <= nr;
        m_fa[k] <= nf;
        m_an[k] <= |(nr | nf);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every instance against the model mid-cycle, then advance to just after the edge.
  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("state[%0d]", k), 32'(st[k]), 32'(m_st[k]));
      chk($sformatf("rise[%0d]", k), 32'(ri[k]), 32'(m_ri[k]));
      chk($sformatf("fall[%0d]", k), 32'(fa[k]), 32'(m_fa[k]));
      chk($sformatf("any[%0d]", k), 32'(an[k]), 32'(m_an[k]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lvl(input int k, input int c, input logic v, input int lim, output int lat);
    lat = 0;
    while (st[k][c] !== v && lat < lim) begin
      cyc();
      lat++;
    end
  endtask

  task automatic align_b();
    for (int i = 0; i < 8 && m_pre[1] != 1; i++) cyc();
  endtask

  initial begin
    int         lat;
    logic [3:0] seen;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      pb[k]  = init_of(k);
    end
    @(posedge clk);
    #1;
    cyc();
    cyc();
    chk("reset_state_a", 32'(st[0]), 32'h0);
    chk("reset_state_c", 32'(st[2]), 32'hF);
    chk("reset_pulses_a", 32'(ri[0] | fa[0]), 32'h0);
    chk("reset_any_b", 32'(an[1]), 32'h0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    repeat (3) cyc();

    // all four channels rise together
    pb[0] = 4'hF;
    wait_lvl(0, 0, 1'b1, 40, lat);
    chk("all_rise_latency", 32'(lat), 32'd18);
    chk("all_rise_pulse", 32'(ri[0]), 32'hF);
    chk("all_rise_any", 32'(an[0]), 32'h1);
    cyc();
    chk("all_rise_any_after", 32'(an[0]), 32'h0);
    chk("all_rise_pulse_after", 32'(ri[0]), 32'h0);
    pb[0] = 4'h0;
    wait_lvl(0, 0, 1'b0, 40, lat);
    repeat (3) cyc();

    // single clean edge on channel 0
    pb[0][0] = 1'b1;
    wait_lvl(0, 0, 1'b1, 40, lat);
    chk("ch0_latency", 32'(lat), 32'd18);
    chk("ch0_rise", 32'(ri[0][0]), 32'h1);
    chk("ch0_any", 32'(an[0]), 32'h1);
    chk("ch0_others", 32'(st[0][3:1]), 32'h0);

    // short pulse on channel 1 must be filtered out
    seen = '0;
    pb[0][1] = 1'b1;
    repeat (10) begin cyc(); seen = seen | ri[0] | fa[0]; end
    pb[0][1] = 1'b0;
    repeat (25) begin cyc(); seen = seen | ri[0] | fa[0]; end
    chk("short_state1", 32'(st[0][1]), 32'h0);
    chk("short_pulses1", 32'(seen[1]), 32'h0);
    chk("short_cnt1", 32'(dut_a.g_ch[1].u_ch.cnt_q), 32'h0);

    // glitch restarts the filter on channel 2
    pb[0][2] = 1'b1;
    repeat (7) cyc();
    pb[0][2] = 1'b0;
    cyc();
    pb[0][2] = 1'b1;
    wait_lvl(0, 2, 1'b1, 40, lat);
    chk("glitch_latency", 32'(lat), 32'd18);

    // prescaled rise then fall on channel 3 of dut_b
    align_b();
    pb[1][3] = 1'b1;
    wait_lvl(1, 3, 1'b1, 80, lat);
    chk("presc_rise_window", 32'(lat >= 60 && lat <= 63), 32'h1);
    chk("presc_rise_pulse", 32'(ri[1][3]), 32'h1);
    repeat (5) cyc();
    align_b();
    pb[1][3] = 1'b0;
    wait_lvl(1, 3, 1'b0, 80, lat);
    chk("presc_fall_window", 32'(lat >= 60 && lat <= 63), 32'h1);
    chk("presc_fall_pulse", 32'(fa[1][3]), 32'h1);
    cyc();
    chk("presc_fall_once", 32'(fa[1][3]), 32'h0);

    // reset in the middle of a count on dut_c
    pb[2][0] = 1'b0;
    repeat (10) cyc();
    chk("midcount_cnt", 32'(dut_c.g_ch[0].u_ch.cnt_q), 32'(m_pend[2][0] ? m_n[2][0] + 1 : 0));
    pb[2] = 4'hF;
    rst[2] = 1'b1;
    repeat (3) cyc();
    rst[2] = 1'b0;
    cyc();
    chk("post_rst_state", 32'(st[2]), 32'hF);
    chk("post_rst_pulses", 32'(ri[2] | fa[2]), 32'h0);
    chk("post_rst_cnt", 32'(dut_c.g_ch[0].u_ch.cnt_q), 32'h0);
    repeat (3) cyc();
    pb[2][0] = 1'b0;
    wait_lvl(2, 0, 1'b0, 40, lat);
    chk("post_rst_fall_latency", 32'(lat), 32'd18);
    chk("post_rst_fall_pulse", 32'(fa[2][0]), 32'h1);

    // random pin activity: a mix of glitches and holds long enough to commit
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 4; c++)
          if ($urandom_range(0, (k == 1) ? 70 : 22) == 0) pb[k][c] = ~pb[k][c];
      if ($urandom_range(0, 400) == 0) rst[2] = 1'b1;
      else rst[2] = 1'b0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
